// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and geometry constants for the HUB75 64x64 1/32-scan driver.
//   scan_state_e    : SHIFT (128 cycles) -> BLANK (1) -> LATCH (1) row sequence.
//   PANEL_COLS      : columns shifted per row.
//   PANEL_HALF_ROWS : row addresses; each address drives one upper and one lower row.
//   SHIFT_CYCLES    : two cycles per column, upper then lower half.
package hub75_pkg;

  typedef enum logic [1:0] {
    SHIFT,
    BLANK,
    LATCH
  } scan_state_e;

  localparam int unsigned PANEL_COLS      = 64;
  localparam int unsigned PANEL_HALF_ROWS = 32;
  localparam int unsigned SHIFT_CYCLES    = 2 * PANEL_COLS;

endpackage

// File: rtl/hub75_scanner_if.sv
// hub75_scanner_if: bundles the painter request/response and the panel pins of the scanner.
//   frame, subframe, x, y, frame_start : scanner -> painter request
//   rgb                                : painter -> scanner, combinational result for (x,y)
//   panel_rgb0/1, panel_addr, panel_sclk, panel_lat, panel_oe_n : scanner -> panel pins
// Modports: master = scanner side, slave = painter/panel side.
interface hub75_scanner_if #(
  parameter int unsigned FRAME_BITS    = 13,
  parameter int unsigned SUBFRAME_BITS = 8
);
  logic [FRAME_BITS-1:0]    frame;
  logic [SUBFRAME_BITS-1:0] subframe;
  logic [5:0]               x;
  logic [5:0]               y;
  logic [2:0]               rgb;
  logic                     frame_start;
  logic [2:0]               panel_rgb0;
  logic [2:0]               panel_rgb1;
  logic [4:0]               panel_addr;
  logic                     panel_sclk;
  logic                     panel_lat;
  logic                     panel_oe_n;

  modport master (
    output frame, subframe, x, y, frame_start,
    output panel_rgb0, panel_rgb1, panel_addr, panel_sclk, panel_lat, panel_oe_n,
    input  rgb
  );

  modport slave (
    input  frame, subframe, x, y, frame_start,
    input  panel_rgb0, panel_rgb1, panel_addr, panel_sclk, panel_lat, panel_oe_n,
    output rgb
  );
endinterface

// File: rtl/hub75_scanner_scan_position.sv
// hub75_scanner_scan_position: chained row -> subframe -> frame counter.
//   clk, resetn     : clock, asynchronous active-low reset
//   i_advance       : one-cycle strobe, advance to the next row (issued in LATCH)
//   o_row           : current row address 0..31
//   o_subframe      : PWM subframe, steps when the row wraps 31 -> 0
//   o_frame         : free-running frame, steps when the subframe wraps all-ones -> 0
//   o_frame_start   : one-cycle pulse in the cycle after the frame steps
module hub75_scanner_scan_position
  import hub75_pkg::*;
#(
  parameter int unsigned FRAME_BITS    = 13,
  parameter int unsigned SUBFRAME_BITS = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_advance,
  output logic [4:0]               o_row,
  output logic [SUBFRAME_BITS-1:0] o_subframe,
  output logic [FRAME_BITS-1:0]    o_frame,
  output logic                     o_frame_start
);

  logic [4:0]               r_row;
  logic [SUBFRAME_BITS-1:0] r_subframe;
  logic [FRAME_BITS-1:0]    r_frame;
  logic                     r_frame_start;
  logic                     w_row_wrap;
  logic                     w_sub_wrap;

  assign w_row_wrap = i_advance && (r_row == 5'(PANEL_HALF_ROWS - 1));
  assign w_sub_wrap = w_row_wrap && (&r_subframe);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row         <= '0;
      r_subframe    <= '0;
      r_frame       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_sub_wrap;
      if (i_advance) r_row <= r_row + 5'd1;
      if (w_row_wrap) r_subframe <= r_subframe + SUBFRAME_BITS'(1);
      if (w_sub_wrap) r_frame <= r_frame + FRAME_BITS'(1);
    end
  end

  assign o_row         = r_row;
  assign o_subframe    = r_subframe;
  assign o_frame       = r_frame;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/hub75_scanner.sv
// hub75_scanner: scan/timing stage for a 64x64 1/32-scan HUB75 panel.
//   clk, resetn : clock, asynchronous active-low reset (synchronous release expected)
//   bus         : hub75_scanner_if.master -- painter request (frame, subframe, x, y,
//                 frame_start), painter response rgb, and the panel pins.
// Each row: 128 SHIFT cycles (column c, phase 0 = upper row, phase 1 = lower row),
// then BLANK (last rising sclk) and LATCH (lat pulse, address update, counters advance).
// The interface must be instantiated with the same FRAME_BITS/SUBFRAME_BITS.
module hub75_scanner
  import hub75_pkg::*;
#(
  parameter int unsigned SUBFRAME_BITS = 8,
  parameter int unsigned FRAME_BITS    = 13
) (
  input logic            clk,
  input logic            resetn,
  hub75_scanner_if.master bus
);

  scan_state_e r_state;
  logic [6:0]  r_cnt;     // {column, phase}
  logic [2:0]  r_hold;    // upper-half pixel waiting for its lower-half partner
  logic [2:0]  r_rgb0;
  logic [2:0]  r_rgb1;
  logic [4:0]  r_addr;
  logic        r_sclk;
  logic        r_lat;
  logic        r_oe_n;
  logic        r_primed;  // a complete row has been latched since reset

  logic [4:0]               w_row;
  logic [SUBFRAME_BITS-1:0] w_subframe;
  logic [FRAME_BITS-1:0]    w_frame;
  logic                     w_frame_start;
  logic                     w_advance;
  logic                     w_phase;
  logic [5:0]               w_col;
  logic                     w_last_shift;

  assign w_advance    = (r_state == LATCH);
  assign w_phase      = r_cnt[0];
  assign w_col        = r_cnt[6:1];
  assign w_last_shift = (r_cnt == 7'(SHIFT_CYCLES - 1));

  hub75_scanner_scan_position #(
    .FRAME_BITS   (FRAME_BITS),
    .SUBFRAME_BITS(SUBFRAME_BITS)
  ) u_scan_position (
    .clk          (clk),
    .resetn       (resetn),
    .i_advance    (w_advance),
    .o_row        (w_row),
    .o_subframe   (w_subframe),
    .o_frame      (w_frame),
    .o_frame_start(w_frame_start)
  );

  // Panel outputs are registered against the state being entered, so lat and the
  // blanking of oe_n line up exactly with BLANK/LATCH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= SHIFT;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_rgb0   <= '0;
      r_rgb1   <= '0;
      r_addr   <= '0;
      r_sclk   <= 1'b0;
      r_lat    <= 1'b0;
      r_oe_n   <= 1'b1;
      r_primed <= 1'b0;
    end else begin
      unique case (r_state)
        SHIFT: begin
          r_cnt <= r_cnt + 7'd1;
          if (!w_phase) begin
            r_hold <= bus.rgb;
            // Rising edge clocks in the previous column; column 0 has none yet.
            r_sclk <= (w_col != 6'd0);
          end else begin
            r_rgb0 <= r_hold;
            r_rgb1 <= bus.rgb;
            r_sclk <= 1'b0;
          end
          if (w_last_shift) begin
            r_state <= BLANK;
            r_oe_n  <= 1'b1;
          end else begin
            r_oe_n  <= ~r_primed;
          end
        end
        BLANK: begin
          r_sclk  <= 1'b1;  // rising edge for column 63
          r_oe_n  <= 1'b1;
          r_lat   <= 1'b1;
          r_state <= LATCH;
        end
        LATCH: begin
          r_lat    <= 1'b0;
          r_sclk   <= 1'b0;
          r_addr   <= w_row;
          r_primed <= 1'b1;
          r_oe_n   <= 1'b0;  // the row just latched is lit while the next one shifts
          r_state  <= SHIFT;
        end
        default: r_state <= SHIFT;
      endcase
    end
  end

  assign bus.frame       = w_frame;
  assign bus.subframe    = w_subframe;
  assign bus.frame_start = w_frame_start;
  assign bus.x           = w_col;
  assign bus.y           = {w_phase, w_row};
  assign bus.panel_rgb0  = r_rgb0;
  assign bus.panel_rgb1  = r_rgb1;
  assign bus.panel_addr  = r_addr;
  assign bus.panel_sclk  = r_sclk;
  assign bus.panel_lat   = r_lat;
  assign bus.panel_oe_n  = r_oe_n;

endmodule

// File: tb/tb_hub75_scanner.sv
// Self-checking bench for hub75_scanner. Expected panel/painter signals are computed
// in closed form from the number of cycles since reset release (130-cycle rows).
module tb_hub75_scanner;

  localparam int unsigned SB       = 2;
  localparam int unsigned FB       = 1;
  localparam int unsigned ROW_CYC  = 130;
  localparam int unsigned NSUB     = 1 << SB;
  localparam int unsigned NFRAME   = 1 << FB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hub75_scanner_if #(.FRAME_BITS(FB), .SUBFRAME_BITS(SB)) bus ();

  hub75_scanner #(
    .SUBFRAME_BITS(SB),
    .FRAME_BITS   (FB)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Painter: either the fixed {y[5], x[0], y[0]} stub or a random pixel table.
  logic [2:0] pix [4096];
  bit         use_table = 1'b0;

  always_comb begin
    if (use_table) bus.rgb = pix[{bus.y, bus.x}];
    else           bus.rgb = {bus.y[5], bus.x[0], bus.y[0]};
  end

  function automatic logic [2:0] painter(input int unsigned c, input int unsigned yy);
    logic [5:0] xb;
    logic [5:0] yb;
    xb = c[5:0];
    yb = yy[5:0];
    if (use_table) return pix[{yb, xb}];
    return {yb[5], xb[0], yb[0]};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input int unsigned t);
    int unsigned n;
    int unsigned k;
    int unsigned row;
    int unsigned c;
    bit          rise;
    n    = t / ROW_CYC;
    k    = t % ROW_CYC;
    row  = n % 32;
    rise = (k == 129) || (k >= 3 && k <= 127 && (k % 2) == 1);
    check_val("sclk", bus.panel_sclk, rise);
    check_val("lat", bus.panel_lat, k == 129);
    check_val("oe_n", bus.panel_oe_n, !(k < 128 && n >= 1));
    check_val("addr", bus.panel_addr, (n == 0) ? 0 : (n - 1) % 32);
    check_val("subframe", bus.subframe, (n / 32) % NSUB);
    check_val("frame", bus.frame, (n / (32 * NSUB)) % NFRAME);
    check_val("frame_start", bus.frame_start, k == 0 && n > 0 && (n % (32 * NSUB)) == 0);
    if (k < 128) begin
      check_val("x", bus.x, k / 2);
      check_val("y", bus.y, (k % 2) * 32 + row);
    end
    if (rise) begin
      c = (k == 129) ? 63 : (k - 1) / 2 - 1;
      check_val("rgb0", bus.panel_rgb0, painter(c, row));
      check_val("rgb1", bus.panel_rgb1, painter(c, row + 32));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_frame"}, bus.frame, 0);
    check_val({tag, "_subframe"}, bus.subframe, 0);
    check_val({tag, "_x"}, bus.x, 0);
    check_val({tag, "_y"}, bus.y, 0);
    check_val({tag, "_frame_start"}, bus.frame_start, 0);
    check_val({tag, "_rgb0"}, bus.panel_rgb0, 0);
    check_val({tag, "_rgb1"}, bus.panel_rgb1, 0);
    check_val({tag, "_sclk"}, bus.panel_sclk, 0);
    check_val({tag, "_lat"}, bus.panel_lat, 0);
    check_val({tag, "_addr"}, bus.panel_addr, 0);
    check_val({tag, "_oe_n"}, bus.panel_oe_n, 1);
  endtask

  initial begin
    int unsigned t_stop;
    int unsigned hold_cyc;

    foreach (pix[i]) pix[i] = 3'($urandom);

    // Phase 1: stub painter, run through two frame wraps and into row 7 of the next frame.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    resetn = 1'b1;
    t_stop = (NSUB * 32 * NFRAME) * ROW_CYC + 7 * ROW_CYC + 60;  // column 30, row 7
    for (int unsigned t = 0; t <= t_stop; t++) begin
      check_cycle(t);
      if (t != t_stop) @(negedge clk);
    end

    // Mid-row reset: asserted between edges, outputs must clear without a clock.
    #2 resetn = 1'b0;
    #1 check_reset_vals("async_rst");
    hold_cyc = $urandom_range(2, 6);
    for (int unsigned i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      check_reset_vals("rst_hold");
    end

    // Phase 2: random painter table after release; scan restarts at row 0, x 0.
    foreach (pix[i]) pix[i] = 3'($urandom);
    use_table = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    for (int unsigned t = 0; t < 3 * ROW_CYC + 40; t++) begin
      check_cycle(t);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_scanner.md
Name: hub75_scanner

Overview:
- Scan/timing stage driving a 64x64 1/32-scan HUB75 panel.
- Generates the frame, subframe and x/y coordinates consumed by the downstream painter stage, and samples the painter's 3-bit rgb result.
- Shifts the sampled pixel pairs into the panel and sequences blank, latch and row address.
- Sits between the painter and the top-level LED_PANEL pin mapping.

Parameters:
- SUBFRAME_BITS, 8, width of the subframe counter; 2^SUBFRAME_BITS PWM subframes per frame.
- FRAME_BITS, 13, width of the free-running frame counter.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- frame  output  FRAME_BITS  current frame number, to painter.
- subframe  output  SUBFRAME_BITS  current subframe, to painter.
- x  output  6  column being requested from painter.
- y  output  6  row being requested from painter (0..63).
- rgb  input  3  painter pixel result for (x,y), combinational, valid same cycle.
- frame_start  output  1  one-cycle pulse when frame increments.
- panel_rgb0  output  3  upper-half pixel data (rows 0..31).
- panel_rgb1  output  3  lower-half pixel data (rows 32..63).
- panel_addr  output  5  row address.
- panel_sclk  output  1  shift clock.
- panel_lat  output  1  latch strobe.
- panel_oe_n  output  1  output enable, low = lit.

Behaviour:
- Reset (async assert, sync release):
  - frame, subframe, x, y, row and phase are all 0; state is SHIFT.
  - panel_rgb0/1 = 0, panel_sclk = 0, panel_lat = 0, panel_addr = 0, panel_oe_n = 1, frame_start = 0.
  - primed = 0.
- States: SHIFT (128 cycles) -> BLANK (1) -> LATCH (1) -> SHIFT. Row period is 130 cycles.
- SHIFT, column c = 0..63, two phases per column:
  - Phase 0: x = c, y = row. rgb is registered into hold. panel_sclk <= 1, except c = 0, where sclk stays 0.
  - Phase 1: x = c, y = row + 32. panel_rgb0 <= hold, panel_rgb1 <= rgb, panel_sclk <= 0.
  - Data therefore changes only while sclk is low and is stable across each rising edge.
- BLANK: panel_sclk <= 1, the rising edge for column 63. panel_oe_n <= 1.
- LATCH:
  - panel_lat = 1, panel_sclk = 0, panel_oe_n = 1, panel_addr <= row.
  - Counters advance: row++. On the 31->0 wrap, subframe++. On the subframe all-ones->0 wrap, frame++ (wrapping at 2^FRAME_BITS) and frame_start pulses for the first cycle of the next SHIFT.
  - primed <= 1.
- Display during SHIFT:
  - panel_oe_n = ~primed, so the row latched previously is lit while the next row shifts.
  - After reset the first 128 cycles stay dark.
- Painter inputs: x, y, frame and subframe are registered outputs and stable for the whole phase in which rgb is sampled. The painter's combinational path must close within one cycle.
- frame and subframe change only in LATCH, so one row's 64 columns always see a single subframe value.
- Reset mid-row: all outputs return to reset values immediately. The partially shifted row is never latched because panel_lat stays 0.

Decomposition:
- Package hub75_pkg holds:
  - state enum {SHIFT, BLANK, LATCH};
  - constants PANEL_COLS = 64, PANEL_HALF_ROWS = 32, SHIFT_CYCLES = 128.
- Optional sub-module scan_position: the chained row/subframe/frame counter with wrap carries and the frame_start pulse.
- The state machine and output registers stay in hub75_scanner.

Test Plan:
- Reset, then 130 cycles:
  - exactly 64 panel_sclk rising edges;
  - one panel_lat pulse at cycle 129;
  - panel_addr = 0 after LATCH;
  - panel_oe_n = 1 throughout.
- Stub painter rgb = {y[5], x[0], y[0]}, row 5:
  - at each sclk rise, panel_rgb0 = {0, c[0], 1};
  - panel_rgb1 = {1, c[0], 1}.
- Second row:
  - panel_oe_n = 0 for all 128 SHIFT cycles;
  - panel_oe_n = 1 in BLANK and LATCH;
  - panel_addr = 0 during SHIFT, 1 after LATCH.
- SUBFRAME_BITS = 2, run 4×32 rows:
  - subframe steps 0..3 then 0;
  - frame goes 0 -> 1;
  - frame_start is high for exactly one cycle, at the first SHIFT cycle after the wrap.
- Force frame to 2^13-1 at the final subframe/row wrap -> frame wraps to 0 and frame_start pulses.
- Assert resetn low at column 30 of row 7:
  - all outputs return to reset values asynchronously;
  - no panel_lat occurs;
  - after release the scan restarts at row 0, x 0.
